// File: rtl/aes_pkg.sv
// AES-128 shared package: FSM encoding, sizes and the combinational GF(2^8) transforms
// used by both the encryption and the decryption controllers.
package aes_pkg;

  localparam int NR        = 10;
  localparam int AES_W     = 128;
  localparam int RK_FLAT_W = (NR + 1) * AES_W;
  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_KEYS   = 3'd1,
    S_INIT_ARK    = 3'd2,
    S_SUBBYTES    = 3'd3,
    S_SHIFTROWS   = 3'd4,
    S_MIXCOL      = 3'd5,
    S_ADDROUNDKEY = 3'd6,
    S_FINISHED    = 3'd7
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Forward S-box computed as the affine map of the inverse b^254 (zero maps to zero).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = b;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [AES_W-1:0] shift_rows_f(input logic [AES_W-1:0] s);
    logic [AES_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [AES_W-1:0] mix_columns_f(input logic [AES_W-1:0] s);
    logic [AES_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Round key i lands in bits [128*i+127 : 128*i] of the flat result.
  function automatic logic [RK_FLAT_W-1:0] key_expand(input logic [AES_W-1:0] key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [RK_FLAT_W-1:0] flat;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      flat[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return flat;
  endfunction

endpackage

// File: rtl/controller_cripto_if.sv
// Request/result bundle between a host and the AES-128 encryption controller.
interface controller_cripto_if;
  logic                     start;
  logic [aes_pkg::AES_W-1:0] chave;
  logic [aes_pkg::AES_W-1:0] palavra;
  logic [aes_pkg::AES_W-1:0] cifra;
  logic                     done;
  logic                     busy;
  logic [2:0]               estado;

  modport master (output start, chave, palavra, input cifra, done, busy, estado);
  modport slave  (input start, chave, palavra, output cifra, done, busy, estado);
endinterface

// File: rtl/AddRoundKey.sv
// AddRoundKey: state XOR round key.
module AddRoundKey
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] st_i,
  input  logic [AES_W-1:0] rk_i,
  output logic [AES_W-1:0] q_o
);
  assign q_o = st_i ^ rk_i;
endmodule

// File: rtl/expansion_key.sv
// AES-128 key schedule, flattened: round key 0 in the low 128 bits.
module expansion_key
  import aes_pkg::*;
(
  input  logic [AES_W-1:0]     key_i,
  output logic [RK_FLAT_W-1:0] rk_o
);
  assign rk_o = key_expand(key_i);
endmodule

// File: rtl/mix_columns.sv
// Forward MixColumns over GF(2^8) with polynomial 0x11B.
module mix_columns
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] d_i,
  output logic [AES_W-1:0] q_o
);
  assign q_o = mix_columns_f(d_i);
endmodule

// File: rtl/shift_rows.sv
// Forward ShiftRows: row r rotated left by r bytes.
module shift_rows
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] d_i,
  output logic [AES_W-1:0] q_o
);
  assign q_o = shift_rows_f(d_i);
endmodule

// File: rtl/sub_bytes.sv
// Forward SubBytes: sixteen independent combinational S-box lookups.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] d_i,
  output logic [AES_W-1:0] q_o
);
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign q_o[8*g +: 8] = sbox(d_i[8*g +: 8]);
  end
endmodule

// File: rtl/controller_cripto.sv
// Iterative AES-128 encryption controller: one transformation per clock,
// 42 cycles from the start edge to the done pulse.
module controller_cripto
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  controller_cripto_if.slave  bus
);

  state_t           state_q;
  logic [3:0]       rnd_q;
  logic [AES_W-1:0] st_q, cifra_q, key_q, pt_q;
  logic [AES_W-1:0] rk_q [0:NR];
  logic             done_q, busy_q;

  logic [RK_FLAT_W-1:0] rk_flat;
  logic [AES_W-1:0]     sb_out, sr_out, mc_out, ark_out, ark_st, ark_key;

  expansion_key u_exp (.key_i(key_q), .rk_o(rk_flat));
  sub_bytes     u_sb  (.d_i(st_q), .q_o(sb_out));
  shift_rows    u_sr  (.d_i(st_q), .q_o(sr_out));
  mix_columns   u_mc  (.d_i(st_q), .q_o(mc_out));

  // One XOR bank serves both the initial whitening and every round.
  assign ark_st  = (state_q == S_INIT_ARK) ? pt_q     : st_q;
  assign ark_key = (state_q == S_INIT_ARK) ? rk_q[0]  : rk_q[rnd_q];
  AddRoundKey   u_ark (.st_i(ark_st), .rk_i(ark_key), .q_o(ark_out));

  // NOTE: capture and key registers are pure datapath loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE && bus.start) begin
      key_q <= bus.chave;
      pt_q  <= bus.palavra;
    end
    if (state_q == S_LOAD_KEYS) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_flat[128*i +: 128];
    end
  end

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      cifra_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_LOAD_KEYS;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD_KEYS: state_q <= S_INIT_ARK;
        S_INIT_ARK: begin
          st_q    <= ark_out;
          rnd_q   <= 4'd1;
          state_q <= S_SUBBYTES;
        end
        S_SUBBYTES: begin
          st_q    <= sb_out;
          state_q <= S_SHIFTROWS;
        end
        S_SHIFTROWS: begin
          st_q    <= sr_out;
          state_q <= (rnd_q == LAST_RND) ? S_ADDROUNDKEY : S_MIXCOL;
        end
        S_MIXCOL: begin
          st_q    <= mc_out;
          state_q <= S_ADDROUNDKEY;
        end
        S_ADDROUNDKEY: begin
          st_q <= ark_out;
          if (rnd_q == LAST_RND) begin
            cifra_q <= ark_out;
            done_q  <= 1'b1;
            state_q <= S_FINISHED;
          end else begin
            rnd_q   <= rnd_q + 4'd1;
            state_q <= S_SUBBYTES;
          end
        end
        S_FINISHED: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cifra  = cifra_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.estado = state_q;

endmodule

// File: tb/tb_controller_cripto.sv
// Directed bench for controller_cripto using FIPS-197 known-answer vectors.
module tb_controller_cripto;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controller_cripto_if bus ();
  controller_cripto dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_B = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected debug state n cycles after the start edge.
  function automatic logic [2:0] exp_state(input int n);
    if (n == 1) return 3'd1;
    if (n == 2) return 3'd2;
    if (n >= 3 && n <= 38) return 3'(3 + ((n - 3) % 4));
    if (n == 39) return 3'd3;
    if (n == 40) return 3'd4;
    if (n == 41) return 3'd6;
    if (n == 42) return 3'd7;
    return 3'd0;
  endfunction

  task automatic run_enc(input logic [127:0] k, input logic [127:0] p, input int ncyc,
                         output int first_done, output int ndone);
    bus.chave = k; bus.palavra = p; bus.start = 1'b1;
    first_done = -1; ndone = 0;
    for (int n = 1; n <= ncyc; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.chave = '0; bus.palavra = '0;
    tick(); tick();
    n_cmp += 4;
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL reset_estado: got %0d want 0", bus.estado); end
    if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    if (bus.cifra !== '0)    begin n_bad++; $display("FAIL reset_cifra: got %h want 0", bus.cifra); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_c1();
    int fd, nd;
    run_enc(K_C1, P_C1, 45, fd, nd);
    n_cmp += 4;
    if (fd !== 42) begin n_bad++; $display("FAIL c1_done_cycle: got %0d want 42", fd); end
    if (nd !== 1)  begin n_bad++; $display("FAIL c1_done_count: got %0d want 1", nd); end
    if (bus.cifra !== C_C1) begin n_bad++; $display("FAIL c1_cifra: got %h want %h", bus.cifra, C_C1); end
    if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL c1_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_appb_trace();
    bus.chave = K_B; bus.palavra = P_B; bus.start = 1'b1;
    for (int n = 1; n <= 44; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
      n_cmp += 3;
      if (bus.estado !== exp_state(n)) begin
        n_bad++; $display("FAIL appb_estado c%0d: got %0d want %0d", n, bus.estado, exp_state(n));
      end
      if (bus.busy !== (n <= 42)) begin
        n_bad++; $display("FAIL appb_busy c%0d: got %b want %b", n, bus.busy, n <= 42);
      end
      if (bus.done !== (n == 42)) begin
        n_bad++; $display("FAIL appb_done c%0d: got %b want %b", n, bus.done, n == 42);
      end
      if (n == 7) begin
        n_cmp++;
        if (dut.st_q !== R1_B) begin n_bad++; $display("FAIL appb_round1: got %h want %h", dut.st_q, R1_B); end
      end
      if (n == 42) begin
        n_cmp++;
        if (bus.cifra !== C_B) begin n_bad++; $display("FAIL appb_cifra: got %h want %h", bus.cifra, C_B); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [0:2];
    logic [127:0] pts  [0:2];
    logic [127:0] cts  [0:2];
    int last_done, idx;
    keys[0] = K_C1; pts[0] = P_C1; cts[0] = C_C1;
    keys[1] = K_B;  pts[1] = P_B;  cts[1] = C_B;
    keys[2] = '0;   pts[2] = '0;   cts[2] = C_Z;
    last_done = -1; idx = 0;
    bus.chave = keys[0]; bus.palavra = pts[0]; bus.start = 1'b1;
    for (int n = 1; n <= 43 * 2 + 42; n++) begin
      tick();
      if (n % 43 == 1) begin
        if (n / 43 + 1 < 3) begin
          bus.chave = keys[n/43+1]; bus.palavra = pts[n/43+1];
        end else begin
          bus.chave = {128{1'b1}}; bus.palavra = {128{1'b1}};
        end
      end
      if (bus.done) begin
        n_cmp += 2;
        if (idx > 2 || bus.cifra !== cts[idx > 2 ? 2 : idx]) begin
          n_bad++; $display("FAIL b2b_cifra%0d: got %h want %h", idx, bus.cifra, cts[idx > 2 ? 2 : idx]);
        end
        if (last_done >= 0 && n - last_done !== 43) begin
          n_bad++; $display("FAIL b2b_period%0d: got %0d want 43", idx, n - last_done);
        end else if (last_done < 0 && n !== 42) begin
          n_bad++; $display("FAIL b2b_first: got %0d want 42", n);
        end
        last_done = n; idx++;
      end
    end
    bus.start = 1'b0;
    tick(); tick(); tick();
    n_cmp += 2;
    if (idx !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", idx); end
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL b2b_idle: got %0d want 0", bus.estado); end
  endtask

  task automatic test_reset_mid();
    int fd, nd;
    bus.chave = K_B; bus.palavra = P_B; bus.start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    n_cmp += 6;
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL mid_estado: got %0d want 0", bus.estado); end
    if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)   begin n_bad++; $display("FAIL mid_done: got %b want 0", bus.done); end
    if (bus.cifra !== '0)    begin n_bad++; $display("FAIL mid_cifra: got %h want 0", bus.cifra); end
    if (dut.rnd_q !== 4'd0)  begin n_bad++; $display("FAIL mid_rnd: got %0d want 0", dut.rnd_q); end
    if (dut.st_q !== '0)     begin n_bad++; $display("FAIL mid_st: got %h want 0", dut.st_q); end
    bus.start = 1'b1;
    tick();
    n_cmp++;
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL rst_start: got %0d want 0", bus.estado); end
    bus.start = 1'b0; rst = 1'b0;
    tick();
    run_enc(K_C1, P_C1, 44, fd, nd);
    n_cmp += 2;
    if (fd !== 42 || nd !== 1) begin n_bad++; $display("FAIL post_rst_done: got cycle %0d count %0d want 42/1", fd, nd); end
    if (bus.cifra !== C_C1) begin n_bad++; $display("FAIL post_rst_cifra: got %h want %h", bus.cifra, C_C1); end
  endtask

  task automatic test_ignore_start();
    int nd;
    nd = 0;
    bus.chave = '0; bus.palavra = '0; bus.start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      bus.start = (n == 4 || n == 41);
      if (bus.done) nd++;
    end
    n_cmp += 3;
    if (nd !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", nd); end
    if (bus.cifra !== C_Z) begin n_bad++; $display("FAIL ign_cifra: got %h want %h", bus.cifra, C_Z); end
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL ign_idle: got %0d want 0", bus.estado); end
  endtask

  initial begin
    test_reset();
    test_c1();
    test_appb_trace();
    test_back_to_back();
    test_reset_mid();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
